// File: rtl/sal_traffic_gen.sv
// Memory traffic generator: writes a seeded pattern, reads it back through
// a slot-tracked out-of-order read engine, and counts mismatching beats.
module sal_traffic_gen #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 128,
  parameter int BEATS      = 2,
  parameter int RA_WIDTH   = 16,
  parameter int CA_WIDTH   = 10,
  parameter int MAX_OUTST  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [15:0]             num_txn,
  input  logic [31:0]             base_addr,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_cnt,
  output logic [31:0]             first_err_addr,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [ID_WIDTH-1:0]     req_id,
  output logic [RA_WIDTH-1:0]     req_ra,
  output logic [CA_WIDTH-1:0]     req_ca,
  output logic                    req_wr,
  output logic [7:0]              req_len,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [ID_WIDTH-1:0]     w_id,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_last,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [ID_WIDTH-1:0]     r_id,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_last
);

  localparam int TXN_BYTES = BEATS * DATA_WIDTH / 8;
  localparam int WORDS     = DATA_WIDTH / 32;
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW        = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, RDRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic [1:0]            mode_reg;
  logic [15:0]           num_reg;
  logic [31:0]           seed_reg, base_reg, addr_reg;
  logic [15:0]           k_reg;
  logic                  req_done_reg, w_done_reg;
  logic [BW-1:0]         w_beat_reg;
  logic [MAX_OUTST-1:0]  alloc_reg;
  logic [15:0]           slot_k_reg [MAX_OUTST];
  logic [BW-1:0]         slot_beat_reg [MAX_OUTST];
  logic                  hold_reg;
  logic [SW-1:0]         hold_slot_reg;
  logic [15:0]           err_cnt_reg;
  logic [31:0]           first_err_addr_reg;

  function automatic logic [DATA_WIDTH-1:0] beat_pattern(input logic [31:0] s,
                                                         input logic [15:0] k,
                                                         input logic [15:0] b);
    return {WORDS{s ^ {k, b}}};
  endfunction

  logic start_ok, last_k, req_fire, w_fire, txn_done, rsp_fire;
  assign start_ok = start && (state_reg == IDLE || state_reg == DONE);
  assign last_k   = (k_reg == num_reg - 16'd1);
  assign req_fire = req_valid && req_ready;
  assign w_fire   = w_valid && w_ready;
  assign txn_done = (req_done_reg || req_fire) && (w_done_reg || (w_fire && w_last));
  assign rsp_fire = r_valid && r_ready;

  // Response decode: one-hot slot hit, and slots released by this cycle's r_last.
  logic [MAX_OUTST-1:0] rsp_hit, rel_mask, free_now;
  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUTST; gi++) begin : g_slot
      assign rsp_hit[gi]  = (r_id == ID_WIDTH'(gi));
      assign rel_mask[gi] = rsp_fire && r_last && rsp_hit[gi] && alloc_reg[gi];
    end
  endgenerate
  assign free_now = ~alloc_reg | rel_mask;

  logic [15:0]   rsp_k;
  logic [BW-1:0] rsp_beat;
  logic          rsp_alloc, rsp_exp_last, rsp_bad, free_any;
  logic [SW-1:0] free_slot, rd_slot;
  logic [31:0]   rsp_err_addr;

  always_comb begin
    rsp_k     = '0;
    rsp_beat  = '0;
    rsp_alloc = 1'b0;
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (rsp_hit[i]) begin
        rsp_k     = slot_k_reg[i];
        rsp_beat  = slot_beat_reg[i];
        rsp_alloc = alloc_reg[i];
      end
    end
    free_any  = 1'b0;
    free_slot = '0;
    for (int i = MAX_OUTST - 1; i >= 0; i--) begin
      if (free_now[i]) begin
        free_any  = 1'b1;
        free_slot = SW'(i);
      end
    end
  end

  // A read offered but not yet accepted keeps its slot so req_id stays stable.
  assign rd_slot      = hold_reg ? hold_slot_reg : free_slot;
  assign rsp_exp_last = (rsp_beat == BW'(BEATS - 1));
  assign rsp_bad      = !rsp_alloc || (r_data != beat_pattern(seed_reg, rsp_k, 16'(rsp_beat))) ||
                        (r_resp != 2'b00) || (r_last != rsp_exp_last);
  assign rsp_err_addr = base_reg + 32'(rsp_k) * 32'(TXN_BYTES);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_valid  = 1'b0;
    req_id     = '0;
    req_wr     = 1'b0;
    w_valid    = 1'b0;
    r_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      WRITE: begin
        busy      = 1'b1;
        req_wr    = 1'b1;
        req_valid = !req_done_reg;
        req_id    = ID_WIDTH'(k_reg);
        w_valid   = !w_done_reg;
        if (txn_done && last_k) state_next = (mode_reg == 2'd0) ? READ : DONE;
      end
      READ: begin
        busy      = 1'b1;
        r_ready   = 1'b1;
        req_valid = hold_reg || free_any;
        req_id    = ID_WIDTH'(rd_slot);
        if (req_fire && last_k) state_next = RDRAIN;
      end
      RDRAIN: begin
        busy    = 1'b1;
        r_ready = 1'b1;
        if (alloc_reg == '0) state_next = DONE;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    if (start_ok) begin
      if (num_txn == 16'd0)   state_next = DONE;
      else if (mode == 2'd2)  state_next = READ;
      else                    state_next = WRITE;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mode_reg           <= '0;
      num_reg            <= '0;
      seed_reg           <= '0;
      base_reg           <= '0;
      addr_reg           <= '0;
      k_reg              <= '0;
      req_done_reg       <= 1'b0;
      w_done_reg         <= 1'b0;
      w_beat_reg         <= '0;
      alloc_reg          <= '0;
      hold_reg           <= 1'b0;
      hold_slot_reg      <= '0;
      err_cnt_reg        <= '0;
      first_err_addr_reg <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        slot_k_reg[i]    <= '0;
        slot_beat_reg[i] <= '0;
      end
    end else if (start_ok) begin
      mode_reg           <= mode;
      num_reg            <= num_txn;
      seed_reg           <= seed;
      base_reg           <= base_addr;
      addr_reg           <= base_addr;
      k_reg              <= '0;
      req_done_reg       <= 1'b0;
      w_done_reg         <= 1'b0;
      w_beat_reg         <= '0;
      alloc_reg          <= '0;
      hold_reg           <= 1'b0;
      err_cnt_reg        <= '0;
      first_err_addr_reg <= '0;
    end else begin
      if (state_reg == WRITE) begin
        if (req_fire) req_done_reg <= 1'b1;
        if (w_fire) begin
          w_beat_reg <= w_last ? '0 : w_beat_reg + BW'(1);
          if (w_last) w_done_reg <= 1'b1;
        end
        if (txn_done) begin
          req_done_reg <= 1'b0;
          w_done_reg   <= 1'b0;
          // Mode 0 replays the same address sequence for the read pass.
          k_reg        <= last_k ? 16'd0 : k_reg + 16'd1;
          addr_reg     <= last_k ? base_reg : addr_reg + 32'(TXN_BYTES);
        end
      end
      if (state_reg == READ) begin
        if (req_fire) begin
          k_reg    <= k_reg + 16'd1;
          addr_reg <= addr_reg + 32'(TXN_BYTES);
          hold_reg <= 1'b0;
        end else if (req_valid) begin
          hold_reg      <= 1'b1;
          hold_slot_reg <= rd_slot;
        end
      end
      if (rsp_fire && rsp_bad) begin
        if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
        if (err_cnt_reg == 16'd0)    first_err_addr_reg <= rsp_err_addr;
      end
      // Allocation is applied after release so a slot can turn around in one cycle.
      for (int i = 0; i < MAX_OUTST; i++) begin
        if (rsp_fire && rsp_hit[i] && alloc_reg[i]) begin
          if (r_last) begin
            alloc_reg[i]     <= 1'b0;
            slot_beat_reg[i] <= '0;
          end else begin
            slot_beat_reg[i] <= (slot_beat_reg[i] == BW'(BEATS - 1)) ? '0 : slot_beat_reg[i] + BW'(1);
          end
        end
        if (state_reg == READ && req_fire && rd_slot == SW'(i)) begin
          alloc_reg[i]     <= 1'b1;
          slot_k_reg[i]    <= k_reg;
          slot_beat_reg[i] <= '0;
        end
      end
    end
  end

  logic addr_unused;
  assign addr_unused    = ^addr_reg;

  assign req_ra         = addr_reg[RA_WIDTH+CA_WIDTH+2:CA_WIDTH+3];
  assign req_ca         = addr_reg[CA_WIDTH+2:3];
  assign req_len        = 8'd1;
  assign w_id           = ID_WIDTH'(k_reg);
  assign w_data         = beat_pattern(seed_reg, k_reg, 16'(w_beat_reg));
  assign w_strb         = '1;
  assign w_last         = (state_reg == WRITE) && (w_beat_reg == BW'(BEATS - 1));
  assign err_cnt        = err_cnt_reg;
  assign first_err_addr = first_err_addr_reg;
  assign pass           = done && (err_cnt_reg == 16'd0);

endmodule

// File: doc/sal_traffic_gen.md
SAL_TRAFFIC_GEN -- requirements
Module: sal_traffic_gen

Interface
REQ-001 Parameters SHALL be:
- ID_WIDTH, 4: request/response ID width.
- DATA_WIDTH, 128: W/R beat width, a multiple of 32.
- BEATS, 2: beats per transaction, at least 1.
- RA_WIDTH, 16: row-address width.
- CA_WIDTH, 10: column-address width.
- MAX_OUTST, 4: maximum reads in flight, at most 2^ID_WIDTH.
REQ-002 Clock and reset SHALL be: clk, in, 1, clock; rst_n, in, 1, reset (asynchronous, active-high).
REQ-003 Control ports SHALL be: start in 1; mode in 2 (0=write+verify, 1=write-only, 2=read+verify); num_txn in 16; base_addr in 32; seed in 32.
REQ-004 Status ports SHALL be:
- busy out 1.
- done out 1.
- pass out 1.
- err_cnt out 16.
- first_err_addr out 32.
REQ-005 Request ports SHALL be: req_valid out 1; req_ready in 1; req_id out ID_WIDTH; req_ra out RA_WIDTH; req_ca out CA_WIDTH; req_wr out 1; req_len out 8.
REQ-006 Write-data ports SHALL be: w_valid out 1; w_ready in 1; w_id out ID_WIDTH; w_data out DATA_WIDTH; w_strb out DATA_WIDTH/8; w_last out 1.
REQ-007 Read-data ports SHALL be: r_valid in 1; r_ready out 1; r_id in ID_WIDTH; r_data in DATA_WIDTH; r_resp in 2; r_last in 1.

Function
REQ-008 The FSM states SHALL be IDLE, WRITE, READ, RDRAIN, DONE.
REQ-009 From IDLE, start SHALL go to WRITE if mode is 0 or 1, and to READ if mode is 2; start SHALL be ignored in any state other than IDLE or DONE.
REQ-010 When num_txn is 0, start SHALL go directly to DONE on the next cycle.
REQ-011 Transaction k SHALL use addr = base_addr + k*BEATS*DATA_WIDTH/8, with the 32-bit sum wrapping.
REQ-012 Address mapping SHALL be req_ca = addr[CA_WIDTH+2:3] and req_ra = addr[RA_WIDTH+CA_WIDTH+2:CA_WIDTH+3].
REQ-013 req_len SHALL be held at 1.
REQ-014 Beat b of transaction k SHALL be DATA_WIDTH/32 copies of (seed XOR {k[15:0], b[15:0]}).
REQ-015 w_strb SHALL be all ones.
REQ-016 w_last SHALL be 1 only on beat BEATS-1.
REQ-017 In WRITE, each transaction SHALL issue its request handshake and its W beats independently; transaction k+1 SHALL NOT start until both the request handshake and the w_last handshake of transaction k have completed.
REQ-018 Write IDs SHALL be k mod 2^ID_WIDTH.
REQ-019 req_valid, w_valid and their payloads SHALL be held stable until the matching ready is seen.
REQ-020 When the last write completes, mode 0 SHALL go to READ and mode 1 SHALL go to DONE.
REQ-021 In READ, a read SHALL issue only when a slot is free in a MAX_OUTST-entry free bitmap.
REQ-022 A read SHALL take the lowest free slot, set req_id to that slot number, and store k in the slot.
REQ-023 Read issue SHALL stall while all slots are busy.
REQ-024 r_ready SHALL be held at 1 in READ and RDRAIN, and at 0 otherwise.
REQ-025 Responses MAY arrive out of order between IDs; the expected data SHALL be derived from the stored k of the slot named by r_id and a per-slot beat counter.
REQ-026 Each accepted beat SHALL add one error, and at most one error, when any of these holds:
- the data mismatches;
- r_resp is not 0;
- r_last is not equal to (beat == BEATS-1);
- r_id names an unallocated slot.
REQ-027 A slot SHALL be freed on the r_last handshake, and a freed slot SHALL be reusable in the same cycle.
REQ-028 After the last read issues, the FSM SHALL go to RDRAIN, and from RDRAIN SHALL go to DONE when all slots are free.
REQ-029 err_cnt SHALL saturate at 16'hFFFF.
REQ-030 first_err_addr SHALL capture the addr of the first error only.
REQ-031 busy SHALL be 1 in WRITE, READ and RDRAIN.
REQ-032 done SHALL be 1 in DONE; pass SHALL equal done AND (err_cnt == 0).
REQ-033 start in DONE SHALL clear err_cnt and first_err_addr and begin a new run.

Reset
REQ-034 While rst_n is high, the FSM SHALL be forced to IDLE immediately; all valid outputs, r_ready, busy, done, pass, err_cnt, first_err_addr and the slot bitmap SHALL be 0.
REQ-035 Reset asserted mid-run SHALL abandon all in-flight transactions, with no pending handshakes retained after release.

Verification
REQ-036 Mode 0, num_txn=2, base 0, seed 0, ready always high -> write IDs 0 and 1 at ca 0 and ca 4; read data from an ideal memory; done=1, pass=1, err_cnt=0.
REQ-037 Same run with the response to slot 1 returned before slot 0 -> pass=1.
REQ-038 Mode 2, MAX_OUTST=4, num_txn=8, responses withheld -> exactly 4 request handshakes, then a stall; after one response, the next read reuses the freed ID.
REQ-039 One beat corrupted in transaction 3 with base 0x100 -> err_cnt=1 and first_err_addr=0x160 (3*32 + 0x100).
REQ-040 start with num_txn=0 -> done=1 within 2 cycles with no handshakes; rst_n pulsed high during WRITE -> all outputs 0 and the FSM in IDLE on the next edge.
